axis_frame_arb: RTL and testbench

- Frame-granular round-robin arbiter sharing one AXI-Stream sink between N requesters, such as the capture dump memory.
- Grants one source at a time and holds the grant until that source's `last` beat completes. This ensures frames are never interleaved at the sink.
- Sits between producer streams (encoder stages, debug taps) and the single dump/capture block.
- Exposes grant and frame-count status for software/debug.

---
 rtl/axis_arb_pkg.sv | 15 +
 rtl/axis_if.sv | 21 ++
 rtl/rr_pick.sv | 39 +++
 rtl/axis_frame_arb.sv | 120 ++++++++++++
 tb/tb_axis_frame_arb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the frame-granular AXI-Stream arbiter.
//   arb_state_t  : arbiter FSM encoding (IDLE = waiting to grant, PASS = frame granted)
//   clog2_min1() : index width for N requesters, never less than 1 bit
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle.
//   data [DW-1:0], vld, last : driven by the producer
//   rdy                      : driven by the consumer
// Handshake: a beat transfers on a rising clock edge where vld and rdy are
// both high. A producer holds data/last stable while vld is high and rdy is
// low; vld must not depend on rdy. rdy may depend combinationally on vld.
interface axis_if #(
  parameter int DW = 64
) ();

  logic [DW-1:0] data;
  logic          vld;
  logic          rdy;
  logic          last;

  // Consumer side (the arbiter's view of a requester).
  modport in  (input data, input vld, input last, output rdy);
  // Producer side (the arbiter's view of the shared sink).
  modport out (output data, output vld, output last, input rdy);

endinterface

// File: rtl/rr_pick.sv
// Cyclic priority search, purely combinational.
//   req     [N]  : request vector
//   ptr     [IW] : highest-priority index this round
//   gnt_idx [IW] : first requester at or after ptr, wrapping past N-1 to 0
//   any          : at least one request is present
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int            pos;
  logic [IW-1:0] pos_idx;

  // Walk from the farthest candidate back to ptr so that the nearest
  // requester (smallest cyclic distance) is the last one assigned.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      pos_idx = IW'(pos);
      if (req[pos_idx]) begin
        any     = 1'b1;
        gnt_idx = pos_idx;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin arbiter: N AXI-Stream requesters share one sink.
// A grant is held until the granted source's last beat transfers, so frames
// never interleave at the sink. One idle cycle separates consecutive frames.
//   clk, a_rst      : clock, asynchronous active-high reset
//   en              : allow new grants (a frame in flight always completes)
//   s_axis[N]       : requester streams
//   m_axis          : shared output stream
//   grant_id        : current or most recent granted source
//   busy            : a frame is granted (FSM in PASS)
//   frames_done     : completed frames, wraps modulo 2^CNT_W
module axis_frame_arb
  import axis_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 64,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       a_rst,
  input  logic                       en,
  axis_if.in                         s_axis [N],
  axis_if.out                        m_axis,
  output logic [clog2_min1(N)-1:0]   grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           frames_done
);

  localparam int IW = clog2_min1(N);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Interface arrays can only be indexed by constants, so flatten them.
  logic [DW-1:0] s_data [N];
  logic [N-1:0]  s_vld;
  logic [N-1:0]  s_last;
  logic [N-1:0]  s_rdy;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign s_data[g]     = s_axis[g].data;
    assign s_vld[g]      = s_axis[g].vld;
    assign s_last[g]     = s_axis[g].last;
    assign s_axis[g].rdy = s_rdy[g];
  end

  logic [IW-1:0] pick_idx;
  logic          pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (s_vld),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  logic          pass;
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic          m_last;
  logic          frame_end;

  // Zero-latency data path: only the registered sel steers the mux.
  always_comb begin
    pass   = (state_q == PASS);
    m_data = s_data[sel_q];
    m_vld  = pass & s_vld[sel_q];
    m_last = pass & s_last[sel_q];
    s_rdy  = '0;
    if (pass) s_rdy[sel_q] = m_axis.rdy;
    frame_end = m_vld & m_axis.rdy & m_last;
  end

  assign m_axis.data = m_data;
  assign m_axis.vld  = m_vld;
  assign m_axis.last = m_last;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          sel_d   = pick_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        if (frame_end) begin
          state_d = IDLE;
          ptr_d   = (int'(sel_q) == N - 1) ? '0 : IW'(int'(sel_q) + 1);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id    = sel_q;
  assign busy        = pass;
  assign frames_done = cnt_q;

endmodule

// File: tb/tb_axis_frame_arb.sv
// Directed bench for axis_frame_arb (N=4, DW=16, CNT_W=4).
// Each source is a small frame generator: it sends req[i] frames of flen[i]
// beats; beat data is {source, frame[3:0], beat[7:0]}. Tests push the
// hand-ordered expected output beats into exp_q.
module tb_axis_frame_arb;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int CNT_W = 4;
  localparam int IW    = 2;

  logic clk = 1'b0;
  logic a_rst;
  logic en;
  always #5 clk = ~clk;

  logic [DW-1:0]    s_data [N];
  logic [N-1:0]     s_vld;
  logic [N-1:0]     s_last;
  logic [N-1:0]     s_rdy;
  logic [DW-1:0]    m_data;
  logic             m_vld;
  logic             m_last;
  logic             m_rdy;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic [CNT_W-1:0] frames_done;

  axis_if #(.DW(DW)) s_if [N] ();
  axis_if #(.DW(DW)) m_if ();

  for (genvar g = 0; g < N; g++) begin : g_src
    assign s_if[g].data = s_data[g];
    assign s_if[g].vld  = s_vld[g];
    assign s_if[g].last = s_last[g];
    assign s_rdy[g]     = s_if[g].rdy;
  end

  assign m_if.rdy = m_rdy;
  assign m_data   = m_if.data;
  assign m_vld    = m_if.vld;
  assign m_last   = m_if.last;

  axis_frame_arb #(.N(N), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .en          (en),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .grant_id    (grant_id),
    .busy        (busy),
    .frames_done (frames_done)
  );

  // ---------------- generator state and scoreboard ----------------
  int            beat [N];
  int            sent [N];
  int            req  [N];
  int            flen [N];
  logic [N-1:0]  hs;
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            busy_cyc = 0;
  int            last_end = -1;
  logic          chk_gap = 1'b0;

  function automatic logic [DW-1:0] mk(input int src, input int frm, input int bt);
    return {4'(src), 4'(frm), 8'(bt)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_vld[i]  = (sent[i] < req[i]);
      s_last[i] = (beat[i] == flen[i] - 1);
      s_data[i] = mk(i, sent[i], beat[i]);
    end
  endtask

  task automatic push_frame(input int src, input int frm, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk(src, frm, b));
  endtask

  // One clock: observe at the falling edge, advance generators just after
  // the rising edge, then let the combinational paths settle.
  task automatic tick();
    @(negedge clk);
    hs = s_vld & s_rdy;
    if (busy) busy_cyc++;
    if (m_vld && m_rdy) begin
      if (exp_q.size() == 0) check("sb_nonempty", 32'(exp_q.size()), 1);
      else                   check("beat", 32'(m_data), 32'(exp_q.pop_front()));
      if (chk_gap && m_data[7:0] == 8'd0 && last_end >= 0) check("gap", 32'(cyc - last_end), 2);
      if (m_last) last_end = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (a_rst) begin
        beat[i] = 0;
      end else if (hs[i]) begin
        if (beat[i] == flen[i] - 1) begin
          beat[i] = 0;
          sent[i]++;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    en    = 1'b0;
    m_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i]  = 0;
      sent[i] = 0;
      beat[i] = 0;
      flen[i] = 1;
    end
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    // Reset / idle
    do_reset();
    check("rst_vld", 32'(m_vld), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frames", 32'(frames_done), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_rdy", 32'(s_rdy), 0);
    en = 1'b1;
    m_rdy = 1'b1;
    repeat (2) tick();
    check("idle_no_req_busy", 32'(busy), 0);

    // Round-robin fairness: 3-beat frames, order 0,1,2,3,0
    do_reset();
    en = 1'b1;
    m_rdy = 1'b1;
    for (int i = 0; i < N; i++) flen[i] = 3;
    req[0] = 2; req[1] = 1; req[2] = 1; req[3] = 1;
    push_frame(0, 0, 3);
    push_frame(1, 0, 3);
    push_frame(2, 0, 3);
    push_frame(3, 0, 3);
    push_frame(0, 1, 3);
    last_end = -1;
    busy_cyc = 0;
    chk_gap = 1'b1;
    drive();
    for (int k = 0; k < 60 && frames_done != 4'd5; k++) tick();
    chk_gap = 1'b0;
    check("fair_frames", 32'(frames_done), 5);
    check("fair_pass_cycles", 32'(busy_cyc), 15);
    check("fair_sb_empty", 32'(exp_q.size()), 0);

    // No interleave under backpressure
    do_reset();
    en = 1'b1;
    m_rdy = 1'b0;
    flen[2] = 4;
    req[2] = 1;
    drive();
    tick();
    check("bp_grant2", 32'(grant_id), 2);
    flen[1] = 2;
    req[1] = 1;
    drive();
    push_frame(2, 0, 4);
    push_frame(1, 0, 2);
    for (int k = 0; k < 40 && frames_done != 4'd2; k++) begin
      m_rdy = ~m_rdy;
      tick();
      if (busy && grant_id == 2'd2) begin
        check("bp_rdy1_low", 32'(s_rdy[1]), 0);
        check("bp_rdy2_pass", 32'(s_rdy[2]), 32'(m_rdy));
      end
    end
    check("bp_frames", 32'(frames_done), 2);
    check("bp_sb_empty", 32'(exp_q.size()), 0);

    // Enable gating
    do_reset();
    en = 1'b1;
    m_rdy = 1'b1;
    flen[0] = 5;
    req[0] = 2;
    push_frame(0, 0, 5);
    push_frame(0, 1, 5);
    drive();
    for (int k = 0; k < 20 && beat[0] != 1; k++) tick();
    en = 1'b0;
    for (int k = 0; k < 20 && frames_done != 4'd1; k++) tick();
    check("en_frame_done", 32'(frames_done), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("en_idle_busy", 32'(busy), 0);
      check("en_idle_vld", 32'(m_vld), 0);
    end
    en = 1'b1;
    tick();
    check("en_regrant_busy", 32'(busy), 1);
    check("en_regrant_gid", 32'(grant_id), 0);
    for (int k = 0; k < 20 && frames_done != 4'd2; k++) tick();
    check("en_frames", 32'(frames_done), 2);
    check("en_sb_empty", 32'(exp_q.size()), 0);

    // Single-beat frames, counter wrap, pointer wrap
    do_reset();
    en = 1'b1;
    m_rdy = 1'b1;
    flen[3] = 1;
    req[3] = 17;
    for (int f = 0; f < 17; f++) push_frame(3, f, 1);
    busy_cyc = 0;
    drive();
    for (int k = 0; k < 60 && sent[3] != 17; k++) tick();
    check("wrap_frames", 32'(frames_done), 1);
    check("wrap_pass_cycles", 32'(busy_cyc), 17);
    check("wrap_sb_empty", 32'(exp_q.size()), 0);
    flen[0] = 1;
    req[0] = 1;
    req[3] = 18;
    push_frame(0, 0, 1);
    push_frame(3, 17, 1);
    drive();
    tick();
    check("tie_busy", 32'(busy), 1);
    check("tie_gid", 32'(grant_id), 0);
    for (int k = 0; k < 20 && frames_done != 4'd3; k++) tick();
    check("tie_frames", 32'(frames_done), 3);
    check("tie_sb_empty", 32'(exp_q.size()), 0);

    // Asynchronous reset mid-frame
    do_reset();
    en = 1'b1;
    m_rdy = 1'b1;
    for (int i = 0; i < N; i++) flen[i] = 4;
    req[2] = 1;
    push_frame(2, 0, 4);
    drive();
    for (int k = 0; k < 10 && beat[2] != 1; k++) tick();
    check("mid_busy_before", 32'(busy), 1);
    #1;
    a_rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_vld", 32'(m_vld), 0);
    check("arst_rdy", 32'(s_rdy), 0);
    check("arst_gid", 32'(grant_id), 0);
    check("arst_frames", 32'(frames_done), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      req[i]  = 1;
    end
    for (int i = 0; i < N; i++) push_frame(i, 0, 4);
    drive();
    tick();
    check("post_rst_busy", 32'(busy), 1);
    check("post_rst_gid", 32'(grant_id), 0);
    for (int k = 0; k < 40 && frames_done != 4'd4; k++) tick();
    check("post_rst_frames", 32'(frames_done), 4);
    check("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
